// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - Shared widths, FSM states and address helpers for the APB requester
package apb_pkg;

  localparam int ADDR_WIDTH  = 16;
  localparam int DATA_WIDTH  = 32;
  localparam int STRB_WIDTH  = DATA_WIDTH / 8;
  localparam int APB_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } apb_state_e;

  // Transfers must be aligned to the full data-bus width.
  function automatic logic validAlign(input logic [ADDR_WIDTH-1:0] addr);
    return (addr % ADDR_WIDTH'(STRB_WIDTH)) == '0;
  endfunction

  // Upper half of the map is privileged, non-secure, instruction space.
  function automatic logic [2:0] getPprot(input logic [ADDR_WIDTH-1:0] addr);
    return addr[ADDR_WIDTH-1] ? 3'b111 : 3'b000;
  endfunction

endpackage

// File: rtl/apb_requester.sv
// rtl/apb_requester.sv - Single-command APB requester with wait-state timeout
module apb_requester #(
  parameter int ADDR_WIDTH = apb_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = apb_pkg::DATA_WIDTH,
  parameter int TIMEOUT    = apb_pkg::APB_TIMEOUT
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_strb,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [2:0]              PPROT,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic                    PREADY,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PSLVERR
);
  import apb_pkg::*;

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  apb_state_e state, next_state;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [STRB_W-1:0]     strb_q;
  logic                  write_q;
  logic                  rsp_valid_q;
  logic                  rsp_err_q;
  logic [CNT_W-1:0]      wait_cnt;
  logic                  load;
  logic                  done;
  logic                  expired;
  logic                  bus_active;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    done       = 1'b0;
    expired    = 1'b0;
    req_ready  = 1'b0;
    PSEL       = 1'b0;
    PENABLE    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (validAlign(req_addr)) begin
            load       = 1'b1;
            next_state = SETUP;
          end else begin
            next_state = ERROR;
          end
        end
      end
      SETUP: begin
        PSEL       = 1'b1;
        next_state = ACCESS;
      end
      ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        // A ready completer on the final allowed cycle still completes normally.
        if (PREADY) begin
          done       = 1'b1;
          next_state = IDLE;
        end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          expired    = 1'b1;
          next_state = IDLE;
        end
      end
      ERROR:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
      write_q     <= 1'b0;
      wait_cnt    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rdata_q     <= '0;
    end else begin
      rsp_valid_q <= done | expired;
      if (load) begin
        addr_q   <= req_addr;
        write_q  <= req_write;
        wdata_q  <= req_write ? req_wdata : '0;
        strb_q   <= req_write ? req_strb : '0;
        wait_cnt <= '0;
      end else if (state == ACCESS && !PREADY) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (done) begin
        rsp_err_q <= PSLVERR;
        rdata_q   <= write_q ? '0 : PRDATA;
      end else if (expired) begin
        rsp_err_q <= 1'b1;
        rdata_q   <= '0;
      end
    end
  end

  assign bus_active = (state == SETUP) || (state == ACCESS);
  assign PADDR      = bus_active ? addr_q : '0;
  assign PWRITE     = bus_active & write_q;
  assign PWDATA     = bus_active ? wdata_q : '0;
  assign PSTRB      = bus_active ? strb_q : '0;
  assign PPROT      = bus_active ? getPprot(addr_q) : 3'b000;

  // Misaligned commands answer combinationally from the ERROR state itself.
  assign rsp_valid  = rsp_valid_q | (state == ERROR);
  assign rsp_err    = rsp_valid_q ? rsp_err_q : (state == ERROR);
  assign rsp_rdata  = rsp_valid_q ? rdata_q : '0;

endmodule

// File: tb/tb_apb_requester.sv
// tb/tb_apb_requester.sv - Directed bench with transaction scoreboard for apb_requester
module tb_apb_requester;

  localparam int TIMEOUT = 16;

  logic        PCLK;
  logic        PRESETn;
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [15:0] PADDR;
  logic [2:0]  PPROT;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;

  apb_requester dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PPROT(PPROT), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int          n_checks = 0;
  int          n_fail = 0;
  int          psel_run = 0;
  int          rsp_count = 0;
  logic [15:0] cur_addr = '0;
  logic        cur_write = 1'b0;
  logic        cur_bus = 1'b0;
  logic [31:0] cur_wdata = '0;
  logic [3:0]  cur_strb = '0;
  logic        exp_err_q[$];
  logic [31:0] exp_rdata_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: bus fields follow the accepted command, responses follow the queue.
  always @(negedge PCLK) begin
    if (PRESETn) begin
      if (PSEL) begin
        if (!cur_bus) begin
          check("psel_without_transfer", 1, 0);
        end else begin
          check("bus_fields", {PADDR, PWRITE, PWDATA, PSTRB, PPROT},
                {cur_addr, cur_write, cur_write ? cur_wdata : 32'h0,
                 cur_write ? cur_strb : 4'h0, cur_addr[15] ? 3'b111 : 3'b000});
          check("penable_phase", PENABLE, psel_run > 0);
          check("access_len", psel_run <= TIMEOUT, 1);
        end
        psel_run++;
      end else begin
        psel_run = 0;
      end
      if (rsp_valid) begin
        rsp_count++;
        if (exp_err_q.size() == 0) begin
          check("rsp_unexpected", 1, 0);
        end else begin
          check("rsp_err", rsp_err, exp_err_q.pop_front());
          check("rsp_rdata", rsp_rdata, exp_rdata_q.pop_front());
        end
      end
    end
  end

  task automatic do_cmd(input logic wr, input logic [15:0] a, input logic [31:0] wd,
                        input logic [3:0] st, input int nwait, input logic serr,
                        input logic [31:0] rd, input int abort_at,
                        output int lat, output int n_acc, output logic err_o,
                        output logic [31:0] rdata_o);
    int guard;
    guard = 0;
    lat = 0;
    n_acc = 0;
    err_o = 1'b0;
    rdata_o = '0;
    while (!req_ready && guard < 8) begin
      @(negedge PCLK); #1;
      guard++;
    end
    check("req_ready_before_cmd", req_ready, 1);
    cur_addr = a; cur_write = wr; cur_wdata = wd; cur_strb = st;
    cur_bus = (a % 16'd4) == 0;
    if (!cur_bus || nwait >= TIMEOUT) begin
      exp_err_q.push_back(1'b1);
      exp_rdata_q.push_back(32'h0);
    end else begin
      exp_err_q.push_back(serr);
      exp_rdata_q.push_back(wr ? 32'h0 : rd);
    end
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; req_strb = st;
    @(posedge PCLK); #1;
    req_valid = 1'b0; req_write = $urandom; req_addr = $urandom;
    req_wdata = $urandom; req_strb = $urandom;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge PCLK); #1;
      if (rsp_valid) begin
        lat = cyc; err_o = rsp_err; rdata_o = rsp_rdata;
        return;
      end
      if (PSEL && PENABLE) begin
        n_acc++;
        if (n_acc == abort_at) begin
          PREADY = 1'b0;
          #2 PRESETn = 1'b0;
          #1;
          check("reset_drops_bus", {PSEL, PENABLE, rsp_valid, req_ready}, 4'b0001);
          void'(exp_err_q.pop_front());
          void'(exp_rdata_q.pop_front());
          @(negedge PCLK); #1;
          PRESETn = 1'b1;
          lat = -1;
          return;
        end
        PREADY  = (n_acc == nwait + 1);
        PRDATA  = PREADY ? rd : (32'hBAD0_0000 ^ cyc);
        PSLVERR = PREADY ? serr : 1'b1;
      end else begin
        PREADY = $urandom; PRDATA = $urandom; PSLVERR = $urandom;
      end
    end
    check("rsp_within_budget", 0, 1);
  endtask

  task automatic expect_vec(input string tag, input int lat, input int nacc, input logic err,
                            input logic [31:0] rd, input int e_lat, input int e_nacc,
                            input logic e_err, input logic [31:0] e_rd);
    check({tag, "_latency"}, lat, e_lat);
    check({tag, "_access_cycles"}, nacc, e_nacc);
    check({tag, "_err"}, err, e_err);
    check({tag, "_rdata"}, rd, e_rd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nacc, seen;
    logic err;
    logic [31:0] rd;
    PRESETn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_strb = '0; PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
    @(negedge PCLK); #1;
    @(negedge PCLK); #1;
    check("reset_outputs", {PSEL, PENABLE, PWRITE, PADDR, PPROT, PWDATA, PSTRB,
                            rsp_valid, rsp_err, rsp_rdata}, '0);
    check("reset_req_ready", req_ready, 1);
    PRESETn = 1'b1;
    @(negedge PCLK); #1;

    do_cmd(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0, 0, lat, nacc, err, rd);
    expect_vec("wr_fast", lat, nacc, err, rd, 3, 1, 1'b0, 32'h0);
    do_cmd(1'b0, 16'h8004, 32'hFFFFFFFF, 4'hF, 3, 1'b0, 32'h12345678, 0, lat, nacc, err, rd);
    expect_vec("rd_wait3", lat, nacc, err, rd, 6, 4, 1'b0, 32'h12345678);
    do_cmd(1'b1, 16'h0002, 32'h0BADBAD0, 4'hF, 0, 1'b0, 32'h0, 0, lat, nacc, err, rd);
    expect_vec("misaligned", lat, nacc, err, rd, 1, 0, 1'b1, 32'h0);
    do_cmd(1'b0, 16'h0020, 32'h0, 4'h0, 100, 1'b0, 32'h55AA55AA, 0, lat, nacc, err, rd);
    expect_vec("timeout", lat, nacc, err, rd, 18, 16, 1'b1, 32'h0);
    do_cmd(1'b0, 16'h0020, 32'h0, 4'h0, 15, 1'b0, 32'hCAFEF00D, 0, lat, nacc, err, rd);
    expect_vec("ready_on_last", lat, nacc, err, rd, 18, 16, 1'b0, 32'hCAFEF00D);
    do_cmd(1'b0, 16'h8008, 32'h13579BDF, 4'hF, 1, 1'b1, 32'h0BADF00D, 0, lat, nacc, err, rd);
    expect_vec("rd_slverr", lat, nacc, err, rd, 4, 2, 1'b1, 32'h0BADF00D);
    do_cmd(1'b1, 16'h0104, 32'hA5A55A5A, 4'h3, 2, 1'b1, 32'hFFFFFFFF, 0, lat, nacc, err, rd);
    expect_vec("wr_slverr", lat, nacc, err, rd, 5, 3, 1'b1, 32'h0);

    seen = rsp_count;
    do_cmd(1'b0, 16'h0040, 32'h0, 4'h0, 10, 1'b0, 32'h77777777, 3, lat, nacc, err, rd);
    check("abort_by_reset", lat < 0, 1);
    repeat (20) @(negedge PCLK);
    #1;
    check("no_rsp_after_reset", rsp_count, seen);
    check("ready_after_reset", req_ready, 1);

    do_cmd(1'b1, 16'h0044, 32'h11223344, 4'hC, 0, 1'b0, 32'h0, 0, lat, nacc, err, rd);
    expect_vec("wr_after_reset", lat, nacc, err, rd, 3, 1, 1'b0, 32'h0);
    repeat (3) @(negedge PCLK);
    #1;
    check("scoreboard_drained", exp_err_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
